multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control FSM for the multi-cycle MIPS core. It sequences the shared PC, instruction register, memory port, ALU and register file across the cycles of each instruction. It also stalls on a memory-ready handshake and counts retired instructions. It sits beside the datapath and drives every write-enable and mux select. It has no datapath of its own.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26]. Stable from DECODE until the next FETCH completes.
- `mem_ready` in 1: memory completes the current read or write this cycle.
- `pc_write` out 1: unconditional PC load.
- `branch_eq` out 1: load PC if ALU zero (beq).
- `branch_ne` out 1: load PC if not zero (bne).
- `pc_source` out 2: 00 ALU result, 01 ALU-out register, 10 jump target.
- `iord` out 1: memory address select, 0 PC, 1 ALU-out.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `ir_write` out 1: IR load.
- `reg_dst` out 1: 0 rt, 1 rd.
- `mem_to_reg` out 1: 0 ALU-out, 1 MDR.
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 1: 0 PC, 1 A.
- `alu_src_b` out 2: 00 B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2.
- `alu_op` out 2: 00 add, 01 sub, 10 use funct.
- `illegal_op` out 1: one-cycle pulse for an unsupported opcode.
- `state` out 4: current state encoding, for debug.
- `instr_count` out CNT_W: count of retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, ADDIEX, ADDIWB.
- Every output is 0 unless listed for the current state.
- IDLE: all outputs 0. Goes to FETCH on the next edge.
- FETCH: `mem_read`=1, `alu_src_b`=01.
  - `ir_write` and `pc_write` are both driven equal to `mem_ready`. These are the only Mealy outputs.
  - Stays in FETCH while `mem_ready`=0. Goes to DECODE when `mem_ready`=1.
- DECODE: `alu_src_b`=11. Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEMADR.
  - 000000 (R-type) → EXEC.
  - 000100 (beq) or 000101 (bne) → BRANCH.
  - 000010 (j) → JUMP.
  - 001000 (addi) → ADDIEX.
  - Any other opcode → FETCH, with `illegal_op`=1 in this DECODE cycle. The instruction is a nop; the PC has already advanced.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: `iord`=1, `mem_read`=1. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB: `mem_to_reg`=1, `reg_write`=1. Goes to FETCH.
- MEMWR: `iord`=1, `mem_write`=1. Holds until `mem_ready`, then goes to FETCH.
- EXEC: `alu_src_a`=1, `alu_op`=10. Goes to ALUWB.
- ALUWB: `reg_dst`=1, `reg_write`=1. Goes to FETCH.
- BRANCH: `alu_src_a`=1, `alu_op`=01, `pc_source`=01.
  - `branch_eq` = ~opcode[0]; `branch_ne` = opcode[0].
  - Goes to FETCH.
- JUMP: `pc_write`=1, `pc_source`=10. Goes to FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10. Goes to ADDIWB.
- ADDIWB: `reg_write`=1. Goes to FETCH.
- `instr_count`:
  - Increments by 1 on each retiring transition into FETCH: from MEMWB, from MEMWR with ready, ALUWB, BRANCH, JUMP and ADDIWB.
  - An illegal opcode does not count.
  - Wraps modulo 2^CNT_W.

## Timing
- Reset (`rst_n` low, asynchronous): state=IDLE, `instr_count`=0, all control outputs 0, `illegal_op`=0.
- Asserting reset mid-instruction aborts the instruction immediately; no write enable stays high.
- The first fetch request appears 1 cycle after reset deasserts.
- Cycles per instruction with zero wait (`mem_ready` high on first request):
  - lw: 5.
  - sw, R-type, addi: 4.
  - beq, bne, j: 3.
  - illegal opcode: 2.
- Each cycle `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle.
- During a stall, request outputs are held constant.
- `mem_ready` outside FETCH, MEMRD and MEMWR is ignored.

## Structure
- Package `mc_pkg` holds:
  - the state enum, 4-bit;
  - opcode constants;
  - `alu_op`, `alu_src_b` and `pc_source` encodings.
- One natural sub-module, `mc_out_decode`: combinational state (plus `opcode`, `mem_ready`) → control outputs.
- The top holds the state register, next-state logic and counter.

## Test plan
- Reset, then deassert `rst_n` with `mem_ready`=1 and `opcode`=000000:
  - state goes IDLE → FETCH → DECODE → EXEC → ALUWB → FETCH;
  - `instr_count`=1 after 5 cycles;
  - `reg_dst`=1 and `reg_write`=1 only in ALUWB.
- lw (100011) with `mem_ready` low for 3 cycles in MEMRD:
  - MEMRD lasts 4 cycles with `iord`=1 and `mem_read`=1 throughout;
  - MEMWB asserts `mem_to_reg`=1 and `reg_write`=1;
  - total 8 cycles.
- FETCH with `mem_ready`=0 for 2 cycles:
  - `ir_write` and `pc_write` stay 0 for those cycles and pulse 1 in the third cycle.
- Opcode 000101 (bne) → BRANCH with `branch_ne`=1, `branch_eq`=0, `alu_op`=01, `pc_source`=01.
  - Repeat with 000100 and the two flags swap.
- Opcode 111111 → `illegal_op` is a 1-cycle pulse in DECODE, the next state is FETCH, and `instr_count` is unchanged.
- Assert `rst_n`=0 asynchronously in MEMWR:
  - `mem_write` drops to 0 within the same cycle and state becomes IDLE;
  - with `CNT_W`=4, 16 retired j instructions wrap `instr_count` to 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main control FSM.
// Holds the state enum, opcode constants, mux-select encodings and the control bundle.
package mc_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Complete set of datapath controls driven each cycle.
  typedef struct packed {
    logic       pc_write;
    logic       branch_eq;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_J)    || (op == OP_BEQ) ||
           (op == OP_BNE)   || (op == OP_ADDI) || (op == OP_LW)  ||
           (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Combinational control decode: current state (plus opcode and mem_ready) to datapath controls.
// FETCH is the only state whose outputs depend on mem_ready.
module mc_out_decode
  import mc_pkg::*;
(
  input  state_t          state,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_ready,
  output ctrl_t           ctrl_c
);

  always_comb begin
    ctrl_c = '0;
    unique case (state)
      S_FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.alu_src_b = SRCB_FOUR;
        ctrl_c.ir_write  = mem_ready;
        ctrl_c.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl_c.alu_src_b  = SRCB_IMM_SH2;
        ctrl_c.illegal_op = ~is_legal(opcode);
      end
      S_MEMADR: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl_c.iord     = 1'b1;
        ctrl_c.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl_c.iord      = 1'b1;
        ctrl_c.mem_write = 1'b1;
      end
      S_EXEC: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl_c.reg_dst   = 1'b1;
        ctrl_c.reg_write = 1'b1;
      end
      // Opcode bit 0 separates bne from beq.
      S_BRANCH: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_op    = ALU_SUB;
        ctrl_c.pc_source = PCSRC_ALUOUT;
        ctrl_c.branch_eq = ~opcode[0];
        ctrl_c.branch_ne = opcode[0];
      end
      S_JUMP: begin
        ctrl_c.pc_write  = 1'b1;
        ctrl_c.pc_source = PCSRC_JUMP;
      end
      S_ADDIEX: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        ctrl_c.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS core: state register, next-state logic
// and retired-instruction counter; output decode lives in mc_out_decode.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             branch_eq,
  output logic             branch_ne,
  output logic [1:0]       pc_source,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  state_t            state_q;
  state_t            state_d;
  logic              retire_c;
  logic [CNT_W-1:0]  cnt_q;
  ctrl_t             ctrl_c;

  // State register; reset aborts any in-flight instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and retire detection.
  always_comb begin
    state_d  = state_q;
    retire_c = 1'b0;
    unique case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = S_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_ADDI:        state_d = S_ADDIEX;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      S_MEMWR: begin
        if (mem_ready) begin
          state_d  = S_FETCH;
          retire_c = 1'b1;
        end
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB: begin
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      S_BRANCH: begin
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      S_JUMP: begin
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: begin
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Retired-instruction counter, wraps naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (retire_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  mc_out_decode u_out_decode (
    .state     (state_q),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctrl_c    (ctrl_c)
  );

  assign pc_write    = ctrl_c.pc_write;
  assign branch_eq   = ctrl_c.branch_eq;
  assign branch_ne   = ctrl_c.branch_ne;
  assign pc_source   = ctrl_c.pc_source;
  assign iord        = ctrl_c.iord;
  assign mem_read    = ctrl_c.mem_read;
  assign mem_write   = ctrl_c.mem_write;
  assign ir_write    = ctrl_c.ir_write;
  assign reg_dst     = ctrl_c.reg_dst;
  assign mem_to_reg  = ctrl_c.mem_to_reg;
  assign reg_write   = ctrl_c.reg_write;
  assign alu_src_a   = ctrl_c.alu_src_a;
  assign alu_src_b   = ctrl_c.alu_src_b;
  assign alu_op      = ctrl_c.alu_op;
  assign illegal_op  = ctrl_c.illegal_op;
  assign state       = STATE_W'(state_q);
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected cycle traces,
// a table of measured instruction latencies, and hand-written reset/wrap sequences.
module tb_multicycle_ctrl;
  import mc_pkg::*;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [5:0]       opcode = '0;
  logic             mem_ready = 1'b1;
  logic             pc_write, branch_eq, branch_ne, iord, mem_read, mem_write;
  logic             ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0]       pc_source, alu_src_b, alu_op;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .branch_eq(branch_eq), .branch_ne(branch_ne),
    .pc_source(pc_source), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .illegal_op(illegal_op), .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic       branch_eq;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_op;
  } outs_t;

  typedef struct {
    state_t s;
    logic   r;
  } step_t;

  typedef struct {
    logic [5:0] op;
    int         fw;
    int         mw;
    int         cyc;
    int         ill;
  } vec_t;

  int               total = 0;
  int               passed = 0;
  logic [CNT_W-1:0] model_cnt = '0;
  step_t            trace[$];
  vec_t             vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic logic legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b000010, 6'b000100, 6'b000101,
                      6'b001000, 6'b100011, 6'b101011};
  endfunction

  // What each state must drive, written straight from the control table.
  function automatic outs_t expect_outs(input state_t s, input logic [5:0] op, input logic r);
    outs_t o = '0;
    case (s)
      S_FETCH:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = r; o.pc_write = r; end
      S_DECODE: begin o.alu_src_b = 2'b11; o.illegal_op = !legal(op); end
      S_MEMADR: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      S_MEMRD:  begin o.iord = 1; o.mem_read = 1; end
      S_MEMWB:  begin o.mem_to_reg = 1; o.reg_write = 1; end
      S_MEMWR:  begin o.iord = 1; o.mem_write = 1; end
      S_EXEC:   begin o.alu_src_a = 1; o.alu_op = 2'b10; end
      S_ALUWB:  begin o.reg_dst = 1; o.reg_write = 1; end
      S_BRANCH: begin
        o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_source = 2'b01;
        o.branch_eq = ~op[0]; o.branch_ne = op[0];
      end
      S_JUMP:   begin o.pc_write = 1; o.pc_source = 2'b10; end
      S_ADDIEX: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      S_ADDIWB: begin o.reg_write = 1; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic outs_t actual_outs();
    return {pc_write, branch_eq, branch_ne, pc_source, iord, mem_read, mem_write,
            ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
            illegal_op};
  endfunction

  // Entered at posedge+1; drives mem_ready, samples mid-cycle, ends at next posedge+1.
  task automatic run_cycle(input state_t s, input logic r);
    mem_ready = r;
    #3;
    chk("state", 32'(state), 32'(s));
    chk("outs", 32'(actual_outs()), 32'(expect_outs(s, opcode, r)));
    chk("count", 32'(instr_count), 32'(model_cnt));
    @(posedge clk);
    #1;
  endtask

  task automatic push(input state_t s, input logic r);
    step_t st;
    st.s = s;
    st.r = r;
    trace.push_back(st);
  endtask

  // Expected cycle trace of one instruction, built from its class and wait counts.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    trace.delete();
    opcode = op;
    for (int i = 0; i < fw; i++) push(S_FETCH, 1'b0);
    push(S_FETCH, 1'b1);
    push(S_DECODE, 1'($urandom));
    case (op)
      OP_LW: begin
        push(S_MEMADR, 1'($urandom));
        for (int i = 0; i < mw; i++) push(S_MEMRD, 1'b0);
        push(S_MEMRD, 1'b1);
        push(S_MEMWB, 1'($urandom));
      end
      OP_SW: begin
        push(S_MEMADR, 1'($urandom));
        for (int i = 0; i < mw; i++) push(S_MEMWR, 1'b0);
        push(S_MEMWR, 1'b1);
      end
      OP_RTYPE: begin push(S_EXEC, 1'($urandom)); push(S_ALUWB, 1'($urandom)); end
      OP_BEQ, OP_BNE: push(S_BRANCH, 1'($urandom));
      OP_J: push(S_JUMP, 1'($urandom));
      OP_ADDI: begin push(S_ADDIEX, 1'($urandom)); push(S_ADDIWB, 1'($urandom)); end
      default: ;
    endcase
    foreach (trace[i]) run_cycle(trace[i].s, trace[i].r);
    if (legal(op)) model_cnt++;
  endtask

  // Drives mem_ready reactively and measures cycles until the DUT is back in FETCH.
  task automatic measure(input vec_t v);
    int cyc = 0;
    int ill_seen = 0;
    int fw = v.fw;
    int mw = v.mw;
    bit left = 0;
    bit done = 0;
    opcode = v.op;
    while (!done && cyc < 40) begin
      cyc++;
      case (state_t'(state))
        S_FETCH: begin mem_ready = (fw == 0); if (fw > 0) fw--; end
        S_MEMRD, S_MEMWR: begin mem_ready = (mw == 0); if (mw > 0) mw--; end
        default: mem_ready = 1'($urandom);
      endcase
      if (state_t'(state) != S_FETCH) left = 1;
      #3;
      if (illegal_op) ill_seen++;
      @(posedge clk);
      #1;
      if (left && state_t'(state) == S_FETCH) done = 1;
    end
    chk("cycles", 32'(cyc), 32'(v.cyc));
    chk("illegal_pulse", 32'(ill_seen), 32'(v.ill));
    if (v.ill == 0) model_cnt++;
    chk("count_after", 32'(instr_count), 32'(model_cnt));
  endtask

  initial begin
    logic [5:0] op;
    vecs[0]  = '{OP_LW,    0, 0, 5, 0};
    vecs[1]  = '{OP_SW,    0, 0, 4, 0};
    vecs[2]  = '{OP_RTYPE, 0, 0, 4, 0};
    vecs[3]  = '{OP_ADDI,  0, 0, 4, 0};
    vecs[4]  = '{OP_BEQ,   0, 0, 3, 0};
    vecs[5]  = '{OP_BNE,   0, 0, 3, 0};
    vecs[6]  = '{OP_J,     0, 0, 3, 0};
    vecs[7]  = '{6'h3f,    0, 0, 2, 1};
    vecs[8]  = '{OP_LW,    0, 3, 8, 0};
    vecs[9]  = '{OP_SW,    2, 1, 7, 0};
    vecs[10] = '{OP_RTYPE, 2, 0, 6, 0};
    vecs[11] = '{6'h11,    1, 0, 3, 1};

    // Reset state, then first R-type after release.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'(S_IDLE));
    chk("rst_outs", 32'(actual_outs()), 32'h0);
    chk("rst_count", 32'(instr_count), 32'h0);
    rst_n = 1'b1;
    run_cycle(S_IDLE, 1'b1);
    run_instr(OP_RTYPE, 0, 0);
    chk("first_count", 32'(instr_count), 32'h1);

    // Fetch stall, branch flag polarity, illegal opcode.
    run_instr(OP_BNE, 2, 0);
    run_instr(OP_BEQ, 0, 0);
    run_instr(6'h3f, 0, 0);
    run_instr(OP_LW, 0, 3);

    for (int i = 0; i < 12; i++) measure(vecs[i]);

    // Random instruction mix with random wait states.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(7))
        0: op = OP_LW;
        1: op = OP_SW;
        2: op = OP_RTYPE;
        3: op = OP_BEQ;
        4: op = OP_BNE;
        5: op = OP_J;
        6: op = OP_ADDI;
        default: begin
          op = 6'($urandom);
          while (legal(op)) op = 6'($urandom);
        end
      endcase
      run_instr(op, int'($urandom_range(2)), int'($urandom_range(3)));
    end

    // Asynchronous reset while a store is waiting in MEMWR.
    opcode = OP_SW;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("memwr_state", 32'(state), 32'(S_MEMWR));
    chk("memwr_write", 32'(mem_write), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_write", 32'(mem_write), 32'h0);
    chk("arst_state", 32'(state), 32'(S_IDLE));
    chk("arst_count", 32'(instr_count), 32'h0);
    model_cnt = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_cycle(S_IDLE, 1'b1);

    // Sixteen jumps wrap a 4-bit counter back to zero.
    for (int i = 0; i < 16; i++) run_instr(OP_J, 0, 0);
    chk("wrap", 32'(instr_count), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
